// File: rtl/store_buffer.sv
// Word-granular store buffer: a FIFO of pending stores ahead of the data memory write port.
// It drains in program order and forwards the youngest matching store to M-stage loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_stall,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  output logic [31:0]      ld_data,
  input  logic             drain_allow,
  output logic             mem_write,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] COUNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             drain;
  logic             accept;
  logic [PTR_W-1:0] fwd_idx;

  // Byte-offset bits are irrelevant for word-granular entries.
  logic unused_lsbs;
  assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign drain    = !empty && drain_allow;
  assign accept   = st_valid && (!full || drain);
  assign st_stall = st_valid && full && !drain;

  assign mem_write      = drain;
  assign mem_address    = empty ? 32'h0 : {addr_q[head], 2'b00};
  assign mem_write_data = empty ? 32'h0 : data_q[head];

  // Entry payload needs no reset: valid bits and count decide what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail] <= st_addr[31:2];
      data_q[tail] <= st_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      // When full, tail equals head, so the accept must override the drain's clear.
      if (drain) begin
        valid_q[head] <= 1'b0;
        head          <= head + PTR_ONE;
      end
      if (accept) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PTR_ONE;
      end
      case ({accept, drain})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = 32'h0;
    fwd_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PTR_W'(i);
      if (ld_valid && valid_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr[31:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-granular FIFO of pending stores between the M-stage store path and data memory's write port (write, address, write_data).
- Decouples store issue from memory write availability. Stores retire into memory in program order.
- Forwards buffered store data to M-stage loads so that a load sees the youngest buffered store to the same word.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, >= 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- st_valid  input  1  M-stage store request this cycle.
- st_addr  input  32  store byte address; only bits [31:2] are used (word aligned).
- st_data  input  32  store word.
- st_stall  output  1  store not accepted this cycle; pipeline holds the store.
- ld_valid  input  1  M-stage load this cycle.
- ld_addr  input  32  load byte address; bits [31:2] compared.
- ld_hit  output  1  a buffered entry matches ld_addr.
- ld_data  output  32  data of the youngest matching entry; 0 when ld_hit=0.
- drain_allow  input  1  memory write port is free this cycle (from hazard/control unit).
- mem_write  output  1  to data memory write.
- mem_address  output  32  to data memory address; {head_addr[31:2], 2'b00}.
- mem_write_data  output  32  to data memory write_data.
- count  output  PTR_W+1  occupied entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.

Behaviour:
- Reset (reset=0, asynchronous): head, tail and count go to 0, and all entry valid bits clear.
  - Outputs during and after reset: empty=1, full=0, mem_write=0, st_stall=0, ld_hit=0, ld_data=0, mem_address=0, mem_write_data=0.
  - Reset mid-operation discards all pending stores. They are never written to memory.
- Storage: DEPTH entries of {addr[31:2], data[31:0]}, a circular buffer with head (oldest) and tail (next free). Pointers wrap modulo DEPTH.
- Drain (combinational): mem_write = !empty & drain_allow, and mem_address/mem_write_data = head entry.
  - Data memory captures the write at the next rising edge. The buffer advances head on that same edge.
  - While mem_write=0, mem_address/mem_write_data show the head entry, or 0 if empty.
- Enqueue: accept = st_valid & (!full | drain). On accept, the entry is written at tail and tail advances at the rising edge.
- Stall: st_stall = st_valid & full & !drain. This is combinational, so the store is held upstream and retried.
  - Full with a simultaneous drain: the store is accepted and count stays DEPTH.
- Count update per edge: +1 on accept without drain, -1 on drain without accept, unchanged otherwise.
- Latency: a store accepted at edge N can drive mem_write in cycle N+1 at the earliest. Zero-cycle bypass of st_data to memory is not allowed.
- Forwarding (combinational):
  - Every valid entry's addr is compared with ld_addr[31:2]. The match nearest tail (youngest) wins and drives ld_data; ld_hit=1.
  - Forwarding is qualified by ld_valid; ld_valid=0 forces ld_hit=0.
  - The entry being drained this cycle still participates.
  - A store presented in the same cycle does not participate. The pipeline never asserts st_valid and ld_valid together; if both are asserted, forwarding uses pre-enqueue contents.
  - On a miss, the load uses data memory's read_data. Selecting between the two is outside this block.
- No coalescing: repeated stores to the same word occupy separate entries and drain in order.
- Ordering: memory writes occur strictly in acceptance order. No entry is skipped or duplicated across pointer wrap.

Test Plan:
- Reset mid-buffer: enqueue 3 stores, hold drain_allow=0, pulse reset low -> count=0, empty=1, mem_write=0, and no memory write occurs afterward with drain_allow=1.
- Fill then stall: drain_allow=0, 5 stores to 0x00,0x04,0x08,0x0C,0x10 (DEPTH=4) -> 4th edge full=1; 5th store st_stall=1 and is not accepted; count=4.
- Full + simultaneous drain: from full, st_valid=1 and drain_allow=1 -> st_stall=0, count stays 4, mem_address=0x00 written; new entry at tail.
- Forwarding youngest: stores 0x40<-0x11111111 then 0x40<-0x22222222, drain_allow=0, load 0x42 -> ld_hit=1, ld_data=0x22222222; load 0x44 -> ld_hit=0, ld_data=0.
- In-order drain with wrap: 10 stores of data=i to addr=4*i with drain_allow toggling 1,0,1,... -> memory write sequence addr 0..0x24 with data 0..9 in order, no duplicates, ends empty=1.
- Store-to-drain latency: empty buffer, drain_allow=1, single store at edge N -> mem_write=0 in cycle N, mem_write=1 in cycle N+1, empty at edge N+1.
